// File: rtl/systolic_wavefront_seq.sv
// systolic_wavefront_seq: skewed operand-valid / K-index / clear-wavefront sequencer for an N x N output-stationary array
//   clk, rst            : clock, async active-high reset
//   start, k_len, abort : job request with reduction depth K, cancel while running
//   busy, done, err     : running, results final (1-cycle), start rejected for K == 0 (1-cycle)
//   lane_valid, lane_k  : per-lane inject strobe and element index for A row i / B column i
//   clear_diag          : bit d clears every PE(r,c) with r+c == d
module systolic_wavefront_seq #(
  parameter int N  = 4,
  parameter int KW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [KW-1:0]     k_len,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [N-1:0]      lane_valid,
  output logic [N*KW-1:0]   lane_k,
  output logic [2*N-2:0]    clear_diag
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_next;
  logic [KW:0] r_t;
  logic [KW-1:0] r_k;
  logic r_err;
  logic w_run, w_accept, w_reject, w_last;
  assign w_run    = r_state == RUN;
  assign w_accept = (r_state == IDLE) && start && (k_len != '0);
  assign w_reject = (r_state == IDLE) && start && (k_len == '0);
  // t is one bit wider than K so the final wavefront K + 2N - 3 never wraps
  assign w_last   = r_t == ((KW+1)'(r_k) + (KW+1)'(2*N-3));
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? (w_accept ? RUN : IDLE) :
             (r_state == RUN)  ? (abort ? IDLE : (w_last ? DONE : RUN)) : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_t     <= '0;
      r_k     <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_t     <= (w_run && w_next == RUN) ? r_t + (KW+1)'(1) : '0;
      r_k     <= w_accept ? k_len : r_k;
      r_err   <= w_reject;
    end
  assign busy = w_run;
  assign done = r_state == DONE;
  assign err  = r_err;
  // lane i runs i cycles behind lane 0 to match the one-register-per-hop skew
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [KW:0] w_d;
    assign w_d = r_t - (KW+1)'(i);
    assign lane_valid[i] = w_run && (r_t >= (KW+1)'(i)) && (w_d < (KW+1)'(r_k));
    assign lane_k[i*KW +: KW] = lane_valid[i] ? w_d[KW-1:0] : '0;
  end
  // PE(r,c) first sees k = 0 at t = r+c, so the clear travels along anti-diagonals
  for (genvar d = 0; d < 2*N-1; d++) begin : g_diag
    assign clear_diag[d] = w_run && (r_t == (KW+1)'(d));
  end
endmodule

// File: tb/tb_systolic_wavefront_seq.sv
// tb_systolic_wavefront_seq: randomized self-checking bench against a cycle-offset reference model
module tb_systolic_wavefront_seq;
  localparam int N  = 4;
  localparam int KW = 8;
  localparam int OW = 3 + N + N*KW + 2*N - 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic abort = 1'b0;
  logic busy, done, err;
  logic [N-1:0] lane_valid;
  logic [N*KW-1:0] lane_k;
  logic [2*N-2:0] clear_diag;
  logic [OW-1:0] obs, ex;
  int n_tests = 0;
  int n_fail = 0;
  systolic_wavefront_seq #(.N(N), .KW(KW)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .abort(abort),
    .busy(busy), .done(done), .err(err),
    .lane_valid(lane_valid), .lane_k(lane_k), .clear_diag(clear_diag)
  );
  always #5 clk = ~clk;
  assign obs = {busy, done, err, lane_valid, lane_k, clear_diag};
  // rel = cycles since the job was accepted (0 = first RUN cycle), negative = no job
  function automatic logic [OW-1:0] exp_vec(int rel, int k, logic e);
    logic bsy, dn;
    logic [N-1:0] lv;
    logic [N*KW-1:0] lk;
    logic [2*N-2:0] cd;
    bsy = rel >= 0 && rel < k + 2*N - 2;
    dn  = rel >= 0 && rel == k + 2*N - 2;
    lv = '0;
    lk = '0;
    cd = '0;
    if (bsy) begin
      for (int i = 0; i < N; i++)
        if (rel >= i && rel - i < k) begin
          lv[i] = 1'b1;
          lk[i*KW +: KW] = KW'(rel - i);
        end
      for (int d = 0; d < 2*N-1; d++) cd[d] = (rel == d);
    end
    return {bsy, dn, e, lv, lk, cd};
  endfunction

  task automatic test_reset;
    #1;
    n_tests++;
    if (obs !== '0) begin n_fail++; $display("FAIL reset_hold got=%h exp=%h", obs, {OW{1'b0}}); end
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (obs !== '0) begin n_fail++; $display("FAIL reset_release got=%h exp=%h", obs, {OW{1'b0}}); end
  endtask

  task automatic test_basic;
    int k = 3;
    @(negedge clk) begin start = 1'b1; k_len = KW'(k); end
    for (int c = 0; c <= k + 2*N; c++) begin
      @(negedge clk) start = 1'b0;
      ex = exp_vec(c, k, 1'b0);
      n_tests++;
      if (obs !== ex) begin n_fail++; $display("FAIL basic c=%0d got=%h exp=%h", c, obs, ex); end
    end
  endtask

  task automatic test_kzero;
    @(negedge clk) begin start = 1'b1; k_len = '0; end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk) start = 1'b0;
      ex = exp_vec(-1, 0, c == 0);
      n_tests++;
      if (obs !== ex) begin n_fail++; $display("FAIL kzero c=%0d got=%h exp=%h", c, obs, ex); end
    end
  endtask

  task automatic test_start_in_run;
    int k = 5;
    int l = k + 2*N - 2;
    @(negedge clk) begin start = 1'b1; k_len = KW'(k); end
    for (int c = 0; c <= l + 1; c++) begin
      @(negedge clk);
      ex = exp_vec(c, k, 1'b0);
      n_tests++;
      if (obs !== ex) begin n_fail++; $display("FAIL start_in_run c=%0d got=%h exp=%h", c, obs, ex); end
      start = (c == 3 || c == l);
      k_len = KW'(5);
    end
    k = 2;
    @(negedge clk) begin start = 1'b1; k_len = KW'(k); end
    for (int c = 0; c <= k + 2*N - 1; c++) begin
      @(negedge clk) start = 1'b0;
      ex = exp_vec(c, k, 1'b0);
      n_tests++;
      if (obs !== ex) begin n_fail++; $display("FAIL restart c=%0d got=%h exp=%h", c, obs, ex); end
    end
  endtask

  task automatic test_abort;
    int nb = 0;
    @(negedge clk) begin start = 1'b1; k_len = KW'(4); end
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      ex = (c <= 2) ? exp_vec(c, 4, 1'b0) : exp_vec(-1, 0, 1'b0);
      n_tests++;
      if (obs !== ex) begin n_fail++; $display("FAIL abort c=%0d got=%h exp=%h", c, obs, ex); end
      abort = (c == 2);
      start = (c == 2);
    end
    @(negedge clk) begin start = 1'b1; k_len = KW'(1); end
    for (int c = 0; c <= 2*N + 1; c++) begin
      @(negedge clk) start = 1'b0;
      ex = exp_vec(c, 1, 1'b0);
      nb += busy ? 1 : 0;
      n_tests++;
      if (obs !== ex) begin n_fail++; $display("FAIL k1 c=%0d got=%h exp=%h", c, obs, ex); end
    end
    n_tests++;
    if (nb !== 2*N - 1) begin n_fail++; $display("FAIL k1_run_len got=%0d exp=%0d", nb, 2*N - 1); end
  endtask

  task automatic test_reset_kmax;
    int k = 255;
    int nd = 0;
    int mx = 0;
    @(negedge clk) begin start = 1'b1; k_len = KW'(10); end
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk) start = 1'b0;
      ex = exp_vec(c, 10, 1'b0);
      n_tests++;
      if (obs !== ex) begin n_fail++; $display("FAIL pre_rst c=%0d got=%h exp=%h", c, obs, ex); end
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (obs !== '0) begin n_fail++; $display("FAIL async_rst got=%h exp=%h", obs, {OW{1'b0}}); end
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (obs !== '0) begin n_fail++; $display("FAIL post_rst got=%h exp=%h", obs, {OW{1'b0}}); end
    @(negedge clk) begin start = 1'b1; k_len = KW'(k); end
    for (int c = 0; c <= k + 2*N; c++) begin
      @(negedge clk) start = 1'b0;
      ex = exp_vec(c, k, 1'b0);
      nd += done ? 1 : 0;
      if (lane_valid[0] && int'(lane_k[KW-1:0]) > mx) mx = int'(lane_k[KW-1:0]);
      n_tests++;
      if (obs !== ex) begin n_fail++; $display("FAIL kmax c=%0d got=%h exp=%h", c, obs, ex); end
    end
    n_tests++;
    if (nd !== 1) begin n_fail++; $display("FAIL kmax_done_count got=%0d exp=1", nd); end
    n_tests++;
    if (mx !== k - 1) begin n_fail++; $display("FAIL kmax_lane0_last got=%0d exp=%0d", mx, k - 1); end
  endtask

  task automatic test_random;
    for (int j = 0; j < 25; j++) begin
      int k = $urandom_range(1, 20);
      int l = k + 2*N - 2;
      int ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, l - 1)) : -1;
      int sp = $urandom_range(0, l);
      @(negedge clk) begin start = 1'b1; k_len = KW'(k); end
      for (int c = 0; c <= l + 1; c++) begin
        @(negedge clk);
        ex = (ab >= 0 && c > ab) ? exp_vec(-1, 0, 1'b0) : exp_vec(c, k, 1'b0);
        n_tests++;
        if (obs !== ex) begin n_fail++; $display("FAIL random j=%0d c=%0d got=%h exp=%h", j, c, obs, ex); end
        start = (c == sp) && (ab < 0 || c <= ab) && (c <= l);
        k_len = KW'($urandom_range(0, 255));
        abort = (c == ab);
      end
      start = 1'b0;
      abort = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_kzero();
    test_start_in_run();
    test_abort();
    test_reset_kmax();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
